// File: rtl/led_pwm_pkg.sv
// Shared constants, types and helpers for the LED PWM block.
// Defaults describe the 32-bit Wishbone LED register: four 8-bit duty fields.
package led_pkg;

  localparam int LED_N_CH       = 4;
  localparam int LED_DUTY_W     = 8;
  localparam int LED_PRESC_W    = 16;
  localparam int LED_PERIOD_MAX = (1 << LED_DUTY_W) - 2;

  typedef logic [LED_DUTY_W-1:0] duty_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  function automatic duty_t duty_field(input logic [LED_N_CH*LED_DUTY_W-1:0] word,
                                       input int k);
    return word[k*LED_DUTY_W +: LED_DUTY_W];
  endfunction

endpackage

// File: rtl/led_pwm_if.sv
// Register-side controls and LED-side outputs of the PWM block.
// The register/driver side is the master; the PWM block is the slave.
interface led_pwm_if
  import led_pkg::*;
#(
  parameter int N_CH    = LED_N_CH,
  parameter int DUTY_W  = LED_DUTY_W,
  parameter int PRESC_W = LED_PRESC_W
);

  logic [N_CH*DUTY_W-1:0] i_duty;
  logic [PRESC_W-1:0]     i_prescale;
  logic                   i_en;
  logic [N_CH-1:0]        o_pwm;
  logic                   o_period;

  modport master (output i_duty, i_prescale, i_en, input o_pwm, o_period);
  modport slave  (input i_duty, i_prescale, i_en, output o_pwm, o_period);

endinterface

// File: rtl/led_prescaler.sv
// Clock-enable generator: one tick every i_prescale+1 clocks while enabled.
// Shared with the blink/heartbeat logic.
module led_prescaler
  import led_pkg::*;
#(
  parameter int PRESC_W = LED_PRESC_W
) (
  input  logic               i_ck,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_tick
);

  logic [PRESC_W-1:0] presc_cnt;

  // >= rather than == so that lowering i_prescale below the running count
  // ticks at once instead of waiting for a full counter wrap.
  assign o_tick = i_en && (presc_cnt >= i_prescale);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      presc_cnt <= '0;
    end else if (!i_en || o_tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm.sv
// Per-channel LED PWM driven from the 32-bit LED register word.
// Duties are shadowed at period starts so bus writes never glitch a pulse.
module led_pwm
  import led_pkg::*;
#(
  parameter int N_CH    = LED_N_CH,
  parameter int DUTY_W  = LED_DUTY_W,
  parameter int PRESC_W = LED_PRESC_W
) (
  input  logic      i_ck,
  input  logic      i_rst,
  led_pwm_if.slave  bus
);

  localparam int PHASE_LAST = (1 << DUTY_W) - 2;

  if (N_CH * DUTY_W != 32) begin : g_cfg_err
    $error("led_pwm: N_CH*DUTY_W must equal 32");
  end

  run_state_t        state, state_next;
  logic              tick;
  logic              period_start;
  logic              start_q;
  logic [DUTY_W-1:0] phase;
  logic [N_CH-1:0]   cmp;

  led_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .i_ck       (i_ck),
    .i_rst      (i_rst),
    .i_en       (bus.i_en),
    .i_prescale (bus.i_prescale),
    .o_tick     (tick)
  );

  always_ff @(posedge i_ck) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // The first tick after enable opens a period without advancing the phase,
  // so the first period has full length and starts with the current duty.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    state_next   = state;
    period_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick) begin
          period_start = 1'b1;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.i_en) state_next = ST_IDLE;
        else if (tick && phase == DUTY_W'(PHASE_LAST)) period_start = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      phase   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= period_start;
      if (!bus.i_en || period_start) phase <= '0;
      else if (tick)                 phase <= phase + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DUTY_W-1:0] shadow;

    // NOTE: the shadow duties are a handful of flops and are cleared on reset
    // so a restart is indistinguishable from power-on.
    always_ff @(posedge i_ck) begin
      if (i_rst) begin
        shadow <= '0;
      end else if (!bus.i_en || period_start) begin
        shadow <= bus.i_duty[k*DUTY_W +: DUTY_W];
      end
    end

    assign cmp[k] = phase < shadow;
  end

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      bus.o_pwm    <= '0;
      bus.o_period <= 1'b0;
    end else begin
      bus.o_pwm    <= (bus.i_en && state == ST_RUN) ? cmp : '0;
      bus.o_period <= bus.i_en && start_q;
    end
  end

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: per-period high-time and period-length
// measurements compared with duty*(prescale+1) and 255*(prescale+1).
module tb_led_pwm;
  import led_pkg::*;

  logic i_ck = 1'b0;
  logic i_rst;

  led_pwm_if bus ();

  led_pwm dut (
    .i_ck  (i_ck),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_ck = ~i_ck;

  int checks = 0;
  int errors = 0;
  int hi_cnt [LED_N_CH];
  int len_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: a duty d at prescale p is high d*(p+1) clocks per period
  // of 255*(p+1) clocks.
  function automatic int exp_high(input logic [31:0] word, input int k, input int p);
    return int'(duty_field(word, k)) * (p + 1);
  endfunction

  function automatic int exp_len(input int p);
    return (LED_PERIOD_MAX + 1) * (p + 1);
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(negedge i_ck);
  endtask

  task automatic wait_period(input int budget, input string tag);
    int n = 0;
    while (bus.o_period !== 1'b1 && n < budget) begin
      @(negedge i_ck);
      n++;
    end
    check(tag, 32'(bus.o_period), 32'd1);
  endtask

  // Called on the first cycle of a period; returns on the first cycle of the
  // next one (if it arrives on time). Optional mid-period input changes.
  task automatic measure(input int plen, input int chg_at, input logic [31:0] new_duty,
                         input int presc_at, input logic [15:0] presc_new);
    len_seen = 0;
    for (int k = 0; k < LED_N_CH; k++) hi_cnt[k] = 0;
    for (int i = 0; i <= plen; i++) begin
      if (i > 0 && len_seen == 0 && bus.o_period === 1'b1) len_seen = i;
      if (i < plen) begin
        for (int k = 0; k < LED_N_CH; k++) hi_cnt[k] += int'(bus.o_pwm[k] === 1'b1);
        if (i == chg_at)   bus.i_duty     = new_duty;
        if (i == presc_at) bus.i_prescale = presc_new;
        @(negedge i_ck);
      end
    end
  endtask

  task automatic check_period(input string tag, input logic [31:0] word, input int p);
    check({tag, ".len"}, 32'(len_seen), 32'(exp_len(p)));
    for (int k = 0; k < LED_N_CH; k++)
      check($sformatf("%s.ch%0d", tag, k), 32'(hi_cnt[k]), 32'(exp_high(word, k, p)));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".pwm"},    32'(bus.o_pwm),    32'd0);
    check({tag, ".period"}, 32'(bus.o_period), 32'd0);
  endtask

  initial begin
    logic [31:0] w, w2;
    int p, at;

    // Reset held with everything asking for full brightness.
    i_rst          = 1'b1;
    bus.i_duty     = 32'hFFFF_FFFF;
    bus.i_en       = 1'b1;
    bus.i_prescale = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_ck);
      check_quiet("reset");
    end

    // Basic duties at prescale 0; first period begins one clock after release.
    bus.i_duty = 32'h00FF_8001;
    i_rst      = 1'b0;
    @(negedge i_ck);
    check_quiet("start");
    @(negedge i_ck);
    check("start.period", 32'(bus.o_period), 32'd1);
    measure(255, -1, '0, -1, '0);
    check_period("basic0", 32'h00FF_8001, 0);
    measure(255, -1, '0, -1, '0);
    check_period("basic1", 32'h00FF_8001, 0);

    // Glitch-free update: ch0 0x10 -> 0xF0 written at phase 0x20.
    measure(255, 0, 32'h00FF_8010, -1, '0);
    measure(255, 32, 32'h00FF_80F0, -1, '0);
    check_period("glitch.cur", 32'h00FF_8010, 0);
    measure(255, -1, '0, -1, '0);
    check_period("glitch.next", 32'h00FF_80F0, 0);

    // Write landing on the period-start clock is captured; one clock later is not.
    measure(255, 253, 32'h1122_3344, -1, '0);
    measure(255, 254, 32'h5566_7788, -1, '0);
    check_period("edge.captured", 32'h1122_3344, 0);
    measure(255, -1, '0, -1, '0);
    check_period("edge.late", 32'h1122_3344, 0);
    measure(255, -1, '0, -1, '0);
    check_period("edge.after", 32'h5566_7788, 0);

    // Prescale 3: 1020-clock period, duty 2 gives 8 high clocks.
    bus.i_en = 1'b0;
    @(negedge i_ck);
    bus.i_prescale = 16'd3;
    bus.i_duty     = 32'h0100_0302;
    bus.i_en       = 1'b1;
    wait_period(10, "presc3.start");
    measure(1020, -1, '0, -1, '0);
    check_period("presc3", 32'h0100_0302, 3);

    // Drop enable mid-period, then restart with ch0 = 0x40.
    bus.i_en = 1'b0;
    @(negedge i_ck);
    bus.i_prescale = '0;
    bus.i_duty     = 32'hFF00_0000;
    bus.i_en       = 1'b1;
    wait_period(10, "en.start");
    clocks(100);
    check("en.before_drop", 32'(bus.o_pwm), 32'h8);
    bus.i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_ck);
      check_quiet("en.low");
    end
    bus.i_duty = 32'h0000_0040;
    bus.i_en   = 1'b1;
    @(negedge i_ck);
    check_quiet("en.rise");
    @(negedge i_ck);
    check("en.rise.period", 32'(bus.o_period), 32'd1);
    measure(255, -1, '0, -1, '0);
    check_period("en.restart", 32'h0000_0040, 0);

    // Lower prescale 100 -> 5 when the prescaler count reaches 50: phase 0
    // lasts 51 clocks, every later phase 6 clocks.
    bus.i_en = 1'b0;
    @(negedge i_ck);
    bus.i_prescale = 16'd100;
    bus.i_duty     = 32'h0000_0201;
    bus.i_en       = 1'b1;
    wait_period(110, "lower.start");
    measure(51 + 254 * 6, -1, '0, 49, 16'd5);
    check("lower.len", 32'(len_seen), 32'(51 + 254 * 6));
    check("lower.ch0", 32'(hi_cnt[0]), 32'd51);
    check("lower.ch1", 32'(hi_cnt[1]), 32'(51 + 6));
    check("lower.ch2", 32'(hi_cnt[2]), 32'd0);
    measure(1530, -1, '0, -1, '0);
    check_period("lower.steady", 32'h0000_0201, 5);

    // Reset mid-run; restart must match power-on.
    clocks(300);
    i_rst = 1'b1;
    @(negedge i_ck);
    check_quiet("midrst");
    clocks(2);
    check_quiet("midrst.hold");
    bus.i_prescale = '0;
    bus.i_duty     = 32'h7F01_FE00;
    i_rst          = 1'b0;
    @(negedge i_ck);
    check_quiet("midrst.release");
    @(negedge i_ck);
    check("midrst.period", 32'(bus.o_period), 32'd1);
    measure(255, -1, '0, -1, '0);
    check_period("midrst.run", 32'h7F01_FE00, 0);

    // Random duties and prescales, with a random mid-period rewrite.
    for (int it = 0; it < 6; it++) begin
      p  = int'($urandom_range(0, 2));
      w  = $urandom();
      w2 = $urandom();
      at = int'($urandom_range(1, 120));
      bus.i_en = 1'b0;
      @(negedge i_ck);
      bus.i_prescale = 16'(p);
      bus.i_duty     = w;
      bus.i_en       = 1'b1;
      wait_period(p + 10, $sformatf("rnd%0d.start", it));
      measure(exp_len(p), at * (p + 1), w2, -1, '0);
      check_period($sformatf("rnd%0d.a", it), w, p);
      measure(exp_len(p), -1, '0, -1, '0);
      check_period($sformatf("rnd%0d.b", it), w2, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
